// File: rtl/dbg_mem_bridge_pkg.sv
// Shared definitions for the debug-to-memory bridge: FSM states and protocol byte codes.
package dbg_mem_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StMem,
    StResp
  } state_e;

  // Command bytes opening a frame.
  localparam logic [7:0] CmdWrite    = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead     = 8'h52;  // 'R'

  // Single-byte responses.
  localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
  localparam logic [7:0] RespBadCmd  = 8'h3F;  // '?'
  localparam logic [7:0] RespTimeout = 8'h54;  // 'T'

  // Response lengths in bytes.
  localparam logic [2:0] LenByte     = 3'd1;
  localparam logic [2:0] LenWord     = 3'd4;

endpackage

// File: rtl/dbg_tx_serializer.sv
// Response buffer: holds up to four bytes and streams them LSB-first over a valid/ready port.
module dbg_tx_serializer
  import dbg_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  left_q, left_d;
  logic        tx_fire;

  assign tx_valid = (left_q != 3'd0);
  assign tx_data  = shift_q[7:0];
  assign tx_fire  = tx_valid && tx_ready;
  // Pulses in the cycle the final byte is accepted.
  assign done     = tx_fire && (left_q == LenByte);

  // Next-state: load a new response, or drop the byte just accepted.
  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    if (load) begin
      shift_d = load_data;
      left_d  = load_len;
    end else if (tx_fire) begin
      shift_d = {8'h00, shift_q[31:8]};
      left_d  = left_q - 3'd1;
    end
  end

  // Buffer and byte-count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
    end
  end

endmodule

// File: rtl/dbg_mem_bridge.sv
// Byte-stream command decoder driving a native memory bus, with timeout and byte responses.
module dbg_mem_bridge
  import dbg_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             mem_valid_q, mem_valid_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [WaitW-1:0] wait_inc;

  logic             rx_fire;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic [2:0]       ld_len;
  logic             tx_done;

  assign rx_ready  = resetn && (state_q == StIdle || state_q == StAddr || state_q == StData);
  assign rx_fire   = rx_valid && rx_ready;
  assign busy      = (state_q != StIdle);
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (state_q == StMem && is_write_q) ? 4'hF : 4'h0;
  assign wait_inc  = wait_q + WaitW'(1);

  // Frame decode, bus access sequencing and response selection.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_valid_d = mem_valid_q;
    wait_d      = wait_q;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_len      = '0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (rx_data == CmdWrite || rx_data == CmdRead) begin
            is_write_d = (rx_data == CmdWrite);
            byte_cnt_d = 2'd0;
            state_d    = StAddr;
          end else begin
            ld_valid = 1'b1;
            ld_data  = {24'h0, RespBadCmd};
            ld_len   = LenByte;
            state_d  = StResp;
          end
        end
      end

      StAddr: begin
        if (rx_fire) begin
          addr_d     = {rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = is_write_q ? StData : StMem;
            wait_d  = '0;
          end
        end
      end

      StData: begin
        if (rx_fire) begin
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StMem;
            wait_d  = '0;
          end
        end
      end

      StMem: begin
        // mem_valid is only low here in the entry cycle; completion clears it on exit.
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          wait_d      = '0;
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          ld_valid    = 1'b1;
          ld_data     = is_write_q ? {24'h0, RespOk} : mem_rdata;
          ld_len      = is_write_q ? LenByte : LenWord;
          state_d     = StResp;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitW'(TIMEOUT_CYCLES)) begin
            mem_valid_d = 1'b0;
            ld_valid    = 1'b1;
            ld_data     = {24'h0, RespTimeout};
            ld_len      = LenByte;
            state_d     = StResp;
          end
        end
      end

      StResp: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_valid_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_valid_q <= mem_valid_d;
      wait_q      <= wait_d;
    end
  end

  dbg_tx_serializer u_tx (
    .clk       (clk),
    .resetn    (resetn),
    .load      (ld_valid),
    .load_data (ld_data),
    .load_len  (ld_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Bench for dbg_mem_bridge: frame-level model plus directed scenarios with literal expectations.
module tb_dbg_mem_bridge;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  dbg_mem_bridge #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Responder: asserts mem_ready after rsp_delay cycles of mem_valid (negative = never).
  int          rsp_delay = 0;
  logic [31:0] rsp_rdata = 32'h0;
  int          rsp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_valid === 1'b1 && !mem_ready) begin
      if (rsp_delay >= 0 && rsp_cnt == rsp_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rsp_rdata;
      end
      rsp_cnt = rsp_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = ~rsp_rdata;
      rsp_cnt   = 0;
    end
  end

  // Frame-level model: accepted bytes -> expected accesses and expected response bytes.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
    int          hi;
  } acc_t;

  logic [7:0] frame[$];
  acc_t       acc_q[$];
  logic [7:0] tx_q[$];
  acc_t       mem_log[$];
  logic [7:0] tx_log[$];
  int         hi_cnt = 0;
  int         last_hi = 0;
  int         start_cd = 0;
  logic       prev_valid = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_tx_data = 8'h00;

  task automatic model_rx(input logic [7:0] b);
    acc_t a;
    logic ok;
    frame.push_back(b);
    if (frame[0] != 8'h57 && frame[0] != 8'h52) begin
      tx_q.push_back(8'h3F);
      frame.delete();
    end else if ((frame[0] == 8'h57 && frame.size() == 9) ||
                 (frame[0] == 8'h52 && frame.size() == 5)) begin
      a.write = (frame[0] == 8'h57);
      a.addr  = {frame[4], frame[3], frame[2], frame[1]} & 32'hFFFF_FFFC;
      a.wdata = a.write ? {frame[8], frame[7], frame[6], frame[5]} : 32'h0;
      a.wstrb = a.write ? 4'hF : 4'h0;
      ok      = (rsp_delay >= 0 && rsp_delay < int'(Tmo));
      a.hi    = ok ? rsp_delay + 1 : int'(Tmo);
      acc_q.push_back(a);
      if (!ok) tx_q.push_back(8'h54);
      else if (a.write) tx_q.push_back(8'h4B);
      else for (int i = 0; i < 4; i++) tx_q.push_back(rsp_rdata[8*i +: 8]);
      start_cd = 2;
      frame.delete();
    end
  endtask

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (!resetn) begin
      frame.delete();
      acc_q.delete();
      tx_q.delete();
      hi_cnt     = 0;
      start_cd   = 0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      logic exp_busy;
      exp_busy = (frame.size() != 0) || (acc_q.size() != 0) || (tx_q.size() != 0);
      chk("mem_instr", {31'h0, mem_instr}, 32'h0);
      chk("busy", {31'h0, busy}, {31'h0, exp_busy});
      chk("rx_ready", {31'h0, rx_ready}, {31'h0, (acc_q.size() == 0 && tx_q.size() == 0)});
      if (start_cd > 0) begin
        start_cd--;
        chk("mem_start", {31'h0, mem_valid}, {31'h0, (start_cd == 0)});
      end
      if (prev_stall) begin
        chk("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
        chk("tx_hold_data", {24'h0, tx_data}, {24'h0, prev_tx_data});
      end
      if (mem_valid) begin
        if (!prev_valid) mem_log.push_back('{mem_addr, mem_wdata, mem_wstrb, 1'b0, 0});
        if (acc_q.size() == 0) fail_now("mem_unexpected");
        else begin
          chk("mem_addr", mem_addr, acc_q[0].addr);
          chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, acc_q[0].wstrb});
          if (acc_q[0].write) chk("mem_wdata", mem_wdata, acc_q[0].wdata);
        end
        hi_cnt++;
      end else if (prev_valid) begin
        last_hi = hi_cnt;
        if (acc_q.size() != 0) begin
          chk("mem_hi_cycles", hi_cnt, acc_q[0].hi);
          void'(acc_q.pop_front());
        end
        hi_cnt = 0;
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        chk("tx_after_access", acc_q.size(), 0);
        if (tx_q.size() == 0) fail_now("tx_unexpected");
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
      prev_stall   = tx_valid && !tx_ready;
      prev_tx_data = tx_data;
      if (rx_valid && rx_ready) model_rx(rx_data);
      prev_valid = mem_valid;
    end
  end

  // Stimulus helpers; all start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 200);
    if (!rx_ready) fail_now("rx_stall_timeout");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    if (busy) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 100);
    if (!mem_valid) fail_now("mem_valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb;
    int mb;
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Write, responder ready after 2 cycles.
    rsp_delay = 2;
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle();
    chk("w_count", mem_log.size(), 1);
    chk("w_addr", mem_log[0].addr, 32'h0000_0010);
    chk("w_wdata", mem_log[0].wdata, 32'hDEAD_BEEF);
    chk("w_wstrb", {28'h0, mem_log[0].wstrb}, 32'hF);
    chk("w_hi", last_hi, 3);
    chk("w_tx", {24'h0, tx_log[0]}, 32'h4B);

    // Read returning 0x12345678.
    rsp_delay = 1;
    rsp_rdata = 32'h1234_5678;
    send_read(32'h0000_0010);
    wait_idle();
    chk("r_wstrb", {28'h0, mem_log[1].wstrb}, 32'h0);
    chk("r_tx_n", tx_log.size(), 5);
    chk("r_tx0", {24'h0, tx_log[1]}, 32'h78);
    chk("r_tx1", {24'h0, tx_log[2]}, 32'h56);
    chk("r_tx2", {24'h0, tx_log[3]}, 32'h34);
    chk("r_tx3", {24'h0, tx_log[4]}, 32'h12);

    // Unknown command, then a normal read.
    mb = mem_log.size();
    tb = tx_log.size();
    send_byte(8'hAA);
    wait_idle();
    chk("bad_no_mem", mem_log.size(), mb);
    chk("bad_tx", {24'h0, tx_log[tb]}, 32'h3F);
    rsp_delay = 0;
    rsp_rdata = 32'hA5A5_0F0F;
    send_read(32'h0000_0104);
    wait_idle();
    chk("bad_next_addr", mem_log[mb].addr, 32'h0000_0104);
    chk("bad_next_tx0", {24'h0, tx_log[tb+1]}, 32'h0F);
    chk("bad_next_tx3", {24'h0, tx_log[tb+4]}, 32'hA5);

    // Timeout, responder never ready; unaligned address is forced to a word.
    rsp_delay = -1;
    tb = tx_log.size();
    mb = mem_log.size();
    send_write(32'h0000_1003, 32'h0BAD_CAFE);
    wait_idle();
    chk("tmo_addr", mem_log[mb].addr, 32'h0000_1000);
    chk("tmo_hi", last_hi, 8);
    chk("tmo_tx", {24'h0, tx_log[tb]}, 32'h54);
    chk("tmo_tx_n", tx_log.size(), tb + 1);

    // Ready on the timeout cycle: completion wins.
    rsp_delay = 7;
    rsp_rdata = 32'h0403_0201;
    tb = tx_log.size();
    send_read(32'h0000_0200);
    wait_idle();
    chk("coin_hi", last_hi, 8);
    chk("coin_tx0", {24'h0, tx_log[tb]}, 32'h01);
    chk("coin_tx_n", tx_log.size(), tb + 4);

    // Ready one cycle too late: timeout.
    rsp_delay = 8;
    tb = tx_log.size();
    send_read(32'h0000_0300);
    wait_idle();
    chk("late_hi", last_hi, 8);
    chk("late_tx", {24'h0, tx_log[tb]}, 32'h54);

    // Backpressure on a read response with the next frame already offered.
    rsp_delay = 0;
    rsp_rdata = 32'hCAFE_F00D;
    tb = tx_log.size();
    fork
      begin
        send_read(32'h0000_0020);
        send_read(32'h0000_0024);
      end
      begin
        int n;
        wait_mem_valid();
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!tx_valid && n < 50);
        repeat (5) begin
          @(negedge clk);
          chk("bp_rx_ready", {31'h0, rx_ready}, 32'h0);
          chk("bp_tx_valid", {31'h0, tx_valid}, 32'h1);
          chk("bp_tx_data", {24'h0, tx_data}, 32'h0D);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_tx_n", tx_log.size(), tb + 8);
    chk("bp_tx0", {24'h0, tx_log[tb]}, 32'h0D);
    chk("bp_tx3", {24'h0, tx_log[tb+3]}, 32'hCA);
    chk("bp_tx7", {24'h0, tx_log[tb+7]}, 32'hCA);

    // Reset while mem_valid is high.
    rsp_delay = -1;
    tb = tx_log.size();
    send_read(32'h0000_0040);
    wait_mem_valid();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("ra_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("ra_busy", {31'h0, busy}, 32'h0);
    chk("ra_tx_valid", {31'h0, tx_valid}, 32'h0);
    repeat (12) @(negedge clk);
    chk("ra_no_tx", tx_log.size(), tb);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame.
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rf_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    rsp_delay = 0;
    rsp_rdata = 32'h0BAD_F00D;
    mb = mem_log.size();
    send_read(32'h0000_0080);
    wait_idle();
    chk("rf_addr", mem_log[mb].addr, 32'h0000_0080);
    chk("rf_wstrb", {28'h0, mem_log[mb].wstrb}, 32'h0);
    chk("rf_tx_n", tx_log.size(), tb + 4);
    chk("rf_tx3", {24'h0, tx_log[tb+3]}, 32'h0B);

    repeat (3) @(negedge clk);
    chk("end_acc_pending", acc_q.size(), 0);
    chk("end_tx_pending", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_mem_bridge.md
DBG_MEM_BRIDGE -- requirements
Module: dbg_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles mem_valid may wait for mem_ready before the access is abandoned.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 rx_data  input  8  command byte stream from the serial side.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  bridge accepts rx_data; a byte transfers when rx_valid and rx_ready are both high.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  sink accepts; a byte transfers when tx_valid and tx_ready are both high.
REQ-010 mem_valid  output  1  native-bus request.
REQ-011 mem_instr  output  1  always 0.
REQ-012 mem_addr  output  32  word address, bits [1:0] forced to 0.
REQ-013 mem_wdata  output  32  write data.
REQ-014 mem_wstrb  output  4  4'hF for writes, 4'h0 for reads.
REQ-015 mem_ready  input  1  responder completion.
REQ-016 mem_rdata  input  32  read data, valid while mem_ready is high.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Frames: 'W' (0x57), then addr 4 bytes LE, then data 4 bytes LE; 'R' (0x52), then addr 4 bytes LE.
REQ-019 FSM states: IDLE, ADDR, DATA, MEM, RESP.
REQ-020 IDLE: on 'W' or 'R', go to ADDR with byte count 0; on any other byte, go to RESP with the single byte 0x3F.
REQ-021 ADDR: shift 4 bytes into the address LSB-first; after the 4th byte, 'W' goes to DATA and 'R' goes to MEM.
REQ-022 DATA: shift 4 bytes into wdata LSB-first, then go to MEM.
REQ-023 rx_ready is high only in IDLE, ADDR and DATA; bytes offered in MEM or RESP are stalled, not dropped.
REQ-024 MEM: mem_valid rises the cycle after entry; mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid is high.
REQ-025 In the cycle mem_ready is sampled high, capture mem_rdata for reads; mem_valid is low the following cycle.
REQ-026 Timeout: a wait counter starts at 0 on MEM entry and increments each cycle mem_valid is high without mem_ready.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES, drop mem_valid next cycle and respond with the single byte 0x54.
REQ-028 If mem_ready and the timeout coincide, completion wins.
REQ-029 RESP for a completed write: the single byte 0x4B.
REQ-030 RESP for a completed read: 4 bytes, rdata LSB-first.
REQ-031 tx_data and tx_valid are held stable until tx_ready; after the last byte transfers, return to IDLE.
REQ-032 Minimum write latency: mem_valid high 1 cycle after the 8th payload byte transfers.
REQ-033 Address wrap: no increment occurs; each frame carries its full address.

Reset
REQ-034 While resetn is low at a clock edge, the FSM returns to IDLE, including mid-frame and mid-access.
REQ-035 Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, tx_valid=0, tx_data=0, busy=0, counters=0.
REQ-036 rx_ready is 1 from the first cycle after reset is released.
REQ-037 A partially received frame is discarded by reset; no response is generated for it.

Structure
REQ-038 Package dbg_mem_bridge_pkg holds the FSM state enum, the command codes 0x57/0x52, and the response codes 0x4B/0x3F/0x54.
REQ-039 One sub-module, dbg_tx_serializer, holds the response buffer, byte count and tx handshake.
REQ-040 All other logic is flat in dbg_mem_bridge.

Verification
REQ-041 Write: stream 57 10 00 00 00 EF BE AD DE, responder ready after 2 cycles -> one access with addr 0x00000010, wdata 0xDEADBEEF, wstrb F; tx byte 4B.
REQ-042 Read: stream 52 10 00 00 00, responder returns 0x12345678 -> wstrb 0; tx bytes 78 56 34 12 in order.
REQ-043 Unknown command: byte 0xAA -> no mem_valid; tx byte 3F; next 'R' frame is handled normally.
REQ-044 Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_valid high exactly 8 cycles, then low; tx byte 54.
REQ-045 Backpressure: tx_ready low for 5 cycles during a read response -> tx_data and tx_valid stable throughout; no byte lost; rx_ready stays 0 until RESP completes.
REQ-046 Reset mid-access: resetn low for 1 cycle while mem_valid is high -> mem_valid 0 next cycle; no tx output; busy 0.
